// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue-side controller for the combinational ALU. Accepts a
//               decoded request over valid/ready, registers the operands and
//               the ALU operation code, captures result/zero one cycle later
//               and returns them over a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_read1,
  output logic [WIDTH-1:0] alu_read2,
  output logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [3:0] C_OP_AND     = 4'b0000;
  localparam logic [3:0] C_OP_OR      = 4'b0001;
  localparam logic [3:0] C_OP_ADD     = 4'b0010;
  localparam logic [3:0] C_OP_SUB     = 4'b0110;
  localparam logic [3:0] C_OP_SLT     = 4'b0111;
  localparam logic [3:0] C_OP_NOR     = 4'b1100;
  localparam logic [3:0] C_OP_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_resp_taken;
  logic [3:0]       w_dec_op;
  logic             w_dec_illegal;

  logic [WIDTH-1:0] r_read1;
  logic [WIDTH-1:0] r_read2;
  logic [3:0]       r_op;
  logic             r_illegal;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_done_count;

  // Decode the instruction fields into the ALU operation code.
  always_comb begin
    w_dec_op      = C_OP_ILLEGAL;
    w_dec_illegal = 1'b1;
    case (in_alu_op)
      2'b00: begin w_dec_op = C_OP_ADD; w_dec_illegal = 1'b0; end
      2'b01: begin w_dec_op = C_OP_SUB; w_dec_illegal = 1'b0; end
      2'b10: begin
        case (in_funct3)
          3'b000: begin
            w_dec_op      = in_funct7b5 ? C_OP_SUB : C_OP_ADD;
            w_dec_illegal = 1'b0;
          end
          3'b111: begin w_dec_op = C_OP_AND; w_dec_illegal = 1'b0; end
          3'b110: begin w_dec_op = C_OP_OR;  w_dec_illegal = 1'b0; end
          3'b010: begin w_dec_op = C_OP_SLT; w_dec_illegal = 1'b0; end
          3'b100: begin
            // NOR shares funct3 with XOR; only the funct7b5 variant is supported.
            if (in_funct7b5) begin
              w_dec_op      = C_OP_NOR;
              w_dec_illegal = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state, input-side ready and handshake qualifiers.
  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    w_accept     = 1'b0;
    w_resp_taken = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // A new request can ride in on the same edge the response leaves.
        in_ready = out_ready;
        if (out_ready) begin
          w_resp_taken = 1'b1;
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ALU-side registers change only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read1   <= '0;
      r_read2   <= '0;
      r_op      <= 4'b0000;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_read1   <= in_a;
      r_read2   <= in_b;
      r_op      <= w_dec_op;
      r_illegal <= w_dec_illegal;
    end
  end

  // Capture the ALU response at the end of the execute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_out_result  <= alu_result;
      r_out_zero    <= alu_zero;
      r_out_illegal <= r_illegal;
    end
  end

  // Count responses taken by the consumer; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_done_count <= '0;
    else if (w_resp_taken) r_done_count <= r_done_count + 1'b1;
  end

  assign alu_read1     = r_read1;
  assign alu_read2     = r_read2;
  assign alu_operation = r_op;
  assign out_valid     = (r_state == ST_DONE);
  assign out_result    = r_out_result;
  assign out_zero      = r_out_zero;
  assign out_illegal   = r_out_illegal;
  assign done_count    = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a
//               behavioural ALU attached to the issue-side ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alu_op;
  logic [2:0]       in_funct3;
  logic             in_funct7b5;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] alu_read1;
  logic [WIDTH-1:0] alu_read2;
  logic [3:0]       alu_operation;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [CNT_W-1:0] done_count;

  int n_vec  = 0;
  int n_bad  = 0;
  int exp_cnt = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_funct3     (in_funct3),
    .in_funct7b5   (in_funct7b5),
    .in_a          (in_a),
    .in_b          (in_b),
    .alu_read1     (alu_read1),
    .alu_read2     (alu_read2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_illegal   (out_illegal),
    .done_count    (done_count)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU driven by the controller's registered outputs.
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      4'b0000: alu_result = alu_read1 & alu_read2;
      4'b0001: alu_result = alu_read1 | alu_read2;
      4'b0010: alu_result = alu_read1 + alu_read2;
      4'b0110: alu_result = alu_read1 - alu_read2;
      4'b0111: alu_result = ($signed(alu_read1) < $signed(alu_read2)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_read1 | alu_read2);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    in_alu_op   = op;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_a        = a;
    in_b        = b;
  endtask

  // Entered #1 after a posedge with the DUT idle and out_ready low; leaves the same way.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] eop, input logic [31:0] eres,
                         input logic ez, input logic eill);
    drive_req(op, f3, f7, a, b);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, ":alu_op"}, 32'(alu_operation), 32'(eop));
    check({tag, ":exec_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ":out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ":result"}, out_result, eres);
    check({tag, ":zero"}, 32'(out_zero), 32'(ez));
    check({tag, ":illegal"}, 32'(out_illegal), 32'(eill));
    check({tag, ":in_ready_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    exp_cnt = (exp_cnt + 1) % 16;
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":cleared"}, 32'(out_valid), 32'd0);
    check({tag, ":count"}, 32'(done_count), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_alu_op   = 2'b00;
    in_funct3   = 3'b000;
    in_funct7b5 = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:count", 32'(done_count), 32'd0);
    check("rst:alu_op", 32'(alu_operation), 32'd0);
    check("rst:result", out_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn("add",    2'b10, 3'b000, 1'b0, 32'd5,        32'd7,        4'b0010, 32'd12,       1'b0, 1'b0);
    run_txn("branch", 2'b01, 3'b000, 1'b0, 32'h1234,     32'h1234,     4'b0110, 32'd0,        1'b1, 1'b0);
    run_txn("ill_op", 2'b11, 3'b000, 1'b0, 32'd9,        32'd3,        4'b1111, 32'd0,        1'b1, 1'b1);
    run_txn("and",    2'b10, 3'b111, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 32'h0F000F00, 1'b0, 1'b0);
    run_txn("mem",    2'b00, 3'b101, 1'b1, 32'd100,      32'd23,       4'b0010, 32'd123,      1'b0, 1'b0);
    run_txn("slt",    2'b10, 3'b010, 1'b0, 32'hFFFFFFFD, 32'd2,        4'b0111, 32'd1,        1'b0, 1'b0);
    run_txn("nor",    2'b10, 3'b100, 1'b1, 32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, 32'h00000F0F, 1'b0, 1'b0);
    run_txn("ill_f3", 2'b10, 3'b001, 1'b0, 32'd4,        32'd4,        4'b1111, 32'd0,        1'b1, 1'b1);
    run_txn("sub",    2'b10, 3'b000, 1'b1, 32'd10,       32'd3,        4'b0110, 32'd7,        1'b0, 1'b0);
    run_txn("xor_no", 2'b10, 3'b100, 1'b0, 32'd6,        32'd1,        4'b1111, 32'd0,        1'b1, 1'b1);

    // Asynchronous reset while a request is in EXEC.
    drive_req(2'b10, 3'b000, 1'b0, 32'd1, 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid:out_valid", 32'(out_valid), 32'd0);
    check("rst_mid:in_ready", 32'(in_ready), 32'd1);
    check("rst_mid:count", 32'(done_count), 32'd0);
    check("rst_mid:alu_op", 32'(alu_operation), 32'd0);
    check("rst_mid:read1", alu_read1, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure: response held for 5 cycles while the next request waits.
    drive_req(2'b10, 3'b000, 1'b1, 32'd50, 32'd8);
    @(posedge clk);
    #1 drive_req(2'b10, 3'b110, 1'b0, 32'hF0, 32'h0F);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp:valid", 32'(out_valid), 32'd1);
      check("bp:result", out_result, 32'd42);
      check("bp:in_ready", 32'(in_ready), 32'd0);
      check("bp:alu_op", 32'(alu_operation), 32'b0110);
    end
    out_ready = 1'b1;
    #1 check("bp:in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_cnt = (exp_cnt + 1) % 16;
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp2:exec_valid", 32'(out_valid), 32'd0);
    check("bp2:alu_op", 32'(alu_operation), 32'b0001);
    check("bp2:count", 32'(done_count), 32'(exp_cnt));
    @(posedge clk);
    @(negedge clk);
    check("bp2:valid", 32'(out_valid), 32'd1);
    check("bp2:result", out_result, 32'hFF);
    out_ready = 1'b1;
    @(posedge clk);
    exp_cnt = (exp_cnt + 1) % 16;
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp2:cleared", 32'(out_valid), 32'd0);
    check("bp2:count2", 32'(done_count), 32'(exp_cnt));
    @(posedge clk);
    #1;

    // 15 more completions give 17 since reset, wrapping the 4-bit counter to 1.
    for (int i = 0; i < 15; i++) begin
      run_txn("wrap_txn", 2'b00, 3'b000, 1'b0, 32'(i), 32'(i + 1), 4'b0010, 32'(2 * i + 1), 1'b0, 1'b0);
    end
    check("wrap:count", 32'(done_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
